// File: rtl/rot_reservation_station.sv
// Reservation station in front of rot_unit.
// Dispatched rotate/shift instructions wait here until all three operands
// (op1, op2, target) are present. Missing operands are captured from the
// common data bus (CDB). Ready entries then issue one per handshake.
// An entry stays allocated after issue until the CDB broadcasts its own
// rs_id, so a tag is never reused while its result is still in flight.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   dispatch_*                    allocation handshake and id of the next free entry
//   op1/op2/target_{in,valid_in,tag_in}  operand value, presence flag, producer tag
//   control_in, result_reg_addr_in       decoded control and destination GPR
//   cdb_valid/cdb_rs_id/cdb_result       result broadcast
//   output_valid/output_ready            issue handshake towards rot_unit
//   rs_id_out, result_reg_addr_out, op1, op2, target, control  issued payload
//                                        (zero whenever output_valid=0)

package rot_rs_pkg;
  typedef struct packed {
    logic [4:0] mb;
    logic [4:0] me;
    logic       mask_insert;
    logic       shift_right;
  } rotate_decode_t;
endpackage

module rot_reservation_station
  import rot_rs_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_DEPTH    = 4,
  parameter int RS_OFFSET   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
  input  logic [31:0]            op1_in,
  input  logic [31:0]            op2_in,
  input  logic [31:0]            target_in,
  input  logic                   op1_valid_in,
  input  logic                   op2_valid_in,
  input  logic                   target_valid_in,
  input  logic [RS_ID_WIDTH-1:0] op1_tag_in,
  input  logic [RS_ID_WIDTH-1:0] op2_tag_in,
  input  logic [RS_ID_WIDTH-1:0] target_tag_in,
  input  rotate_decode_t         control_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [31:0]            op1,
  output logic [31:0]            op2,
  output logic [31:0]            target,
  output rotate_decode_t         control
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  typedef enum logic [1:0] {S_FREE, S_WAITING, S_READY, S_ISSUED} rs_state_e;

  rs_state_e                          state_q   [RS_DEPTH];
  rs_state_e                          state_d   [RS_DEPTH];
  logic [2:0]                         op_vld_q  [RS_DEPTH];
  logic [2:0]                         op_vld_d  [RS_DEPTH];
  logic [2:0][31:0]                   op_val_q  [RS_DEPTH];
  logic [2:0][31:0]                   op_val_d  [RS_DEPTH];
  logic [2:0][RS_ID_WIDTH-1:0]        op_tag_q  [RS_DEPTH];
  logic [2:0][RS_ID_WIDTH-1:0]        op_tag_d  [RS_DEPTH];
  rotate_decode_t                     ctrl_q    [RS_DEPTH];
  rotate_decode_t                     ctrl_d    [RS_DEPTH];
  logic [4:0]                         rd_q      [RS_DEPTH];
  logic [4:0]                         rd_d      [RS_DEPTH];
  logic                               lock_q, lock_d;
  logic [IDX_W-1:0]                   lock_idx_q, lock_idx_d;

  logic             any_free, any_ready, dispatch_fire, issue_fire;
  logic [IDX_W-1:0] alloc_idx, ready_idx, sel_idx;

  // Operand slot 0 = op1, 1 = op2, 2 = target.
  logic [2:0][31:0]            din_val;
  logic [2:0]                  din_vld;
  logic [2:0][RS_ID_WIDTH-1:0] din_tag;
  assign din_val = {target_in, op2_in, op1_in};
  assign din_vld = {target_valid_in, op2_valid_in, op1_valid_in};
  assign din_tag = {target_tag_in, op2_tag_in, op1_tag_in};

  // Lowest-index FREE and READY entries, from registered state only.
  always_comb begin
    any_free  = 1'b0;
    any_ready = 1'b0;
    alloc_idx = '0;
    ready_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == S_FREE) begin
        any_free  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (state_q[i] == S_READY) begin
        any_ready = 1'b1;
        ready_idx = IDX_W'(i);
      end
    end
  end

  // A locked selection keeps the payload stable until it is accepted.
  assign sel_idx        = lock_q ? lock_idx_q : ready_idx;
  assign dispatch_ready = any_free && !rst;
  assign dispatch_rs_id = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(alloc_idx);
  assign output_valid   = (lock_q || any_ready) && !rst;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;
  assign issue_fire     = output_valid && output_ready;

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (issue_fire) begin
      lock_d = 1'b0;
    end else if (output_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      state_d[i]  = state_q[i];
      op_vld_d[i] = op_vld_q[i];
      op_val_d[i] = op_val_q[i];
      op_tag_d[i] = op_tag_q[i];
      ctrl_d[i]   = ctrl_q[i];
      rd_d[i]     = rd_q[i];
      case (state_q[i])
        S_FREE: begin
          if (dispatch_fire && (alloc_idx == IDX_W'(i))) begin
            op_vld_d[i] = din_vld;
            op_val_d[i] = din_val;
            op_tag_d[i] = din_tag;
            ctrl_d[i]   = control_in;
            rd_d[i]     = result_reg_addr_in;
            // Producer broadcasting right now would otherwise be missed.
            for (int k = 0; k < 3; k++) begin
              if (!din_vld[k] && cdb_valid && (din_tag[k] == cdb_rs_id)) begin
                op_vld_d[i][k] = 1'b1;
                op_val_d[i][k] = cdb_result;
              end
            end
            state_d[i] = (&op_vld_d[i]) ? S_READY : S_WAITING;
          end
        end
        S_WAITING: begin
          for (int k = 0; k < 3; k++) begin
            if (!op_vld_q[i][k] && cdb_valid && (op_tag_q[i][k] == cdb_rs_id)) begin
              op_vld_d[i][k] = 1'b1;
              op_val_d[i][k] = cdb_result;
            end
          end
          if (&op_vld_d[i]) state_d[i] = S_READY;
        end
        S_READY: begin
          if (issue_fire && (sel_idx == IDX_W'(i))) state_d[i] = S_ISSUED;
        end
        S_ISSUED: begin
          if (cdb_valid && (cdb_rs_id == RS_ID_WIDTH'(RS_OFFSET + i))) state_d[i] = S_FREE;
        end
        default: state_d[i] = S_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) state_q[i] <= S_FREE;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int i = 0; i < RS_DEPTH; i++) state_q[i] <= state_d[i];
    end
  end

  // Entry payload is only meaningful while the entry is allocated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      op_vld_q[i] <= op_vld_d[i];
      op_val_q[i] <= op_val_d[i];
      op_tag_q[i] <= op_tag_d[i];
      ctrl_q[i]   <= ctrl_d[i];
      rd_q[i]     <= rd_d[i];
    end
  end

  always_comb begin
    rs_id_out           = '0;
    result_reg_addr_out = '0;
    op1                 = '0;
    op2                 = '0;
    target              = '0;
    control             = '0;
    if (output_valid) begin
      rs_id_out           = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(sel_idx);
      result_reg_addr_out = rd_q[sel_idx];
      op1                 = op_val_q[sel_idx][0];
      op2                 = op_val_q[sel_idx][1];
      target              = op_val_q[sel_idx][2];
      control             = ctrl_q[sel_idx];
    end
  end

endmodule

// File: tb/tb_rot_reservation_station.sv
module tb_rot_reservation_station;
  import rot_rs_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           dispatch_valid;
  logic           dispatch_ready;
  logic [4:0]     dispatch_rs_id;
  logic [31:0]    op1_in, op2_in, target_in;
  logic           op1_valid_in, op2_valid_in, target_valid_in;
  logic [4:0]     op1_tag_in, op2_tag_in, target_tag_in;
  rotate_decode_t control_in;
  logic [4:0]     result_reg_addr_in;
  logic           cdb_valid;
  logic [4:0]     cdb_rs_id;
  logic [31:0]    cdb_result;
  logic           output_valid;
  logic           output_ready;
  logic [4:0]     rs_id_out;
  logic [4:0]     result_reg_addr_out;
  logic [31:0]    op1, op2, target;
  rotate_decode_t control;

  int n_vec = 0;
  int n_bad = 0;
  rotate_decode_t ctrl_a;

  rot_reservation_station #(.RS_ID_WIDTH(5), .RS_DEPTH(4), .RS_OFFSET(0)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_rs_id(dispatch_rs_id),
    .op1_in(op1_in), .op2_in(op2_in), .target_in(target_in),
    .op1_valid_in(op1_valid_in), .op2_valid_in(op2_valid_in),
    .target_valid_in(target_valid_in),
    .op1_tag_in(op1_tag_in), .op2_tag_in(op2_tag_in), .target_tag_in(target_tag_in),
    .control_in(control_in), .result_reg_addr_in(result_reg_addr_in),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .output_valid(output_valid), .output_ready(output_ready),
    .rs_id_out(rs_id_out), .result_reg_addr_out(result_reg_addr_out),
    .op1(op1), .op2(op2), .target(target), .control(control)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_disp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic av, input logic bv, input logic cv,
                            input logic [4:0] at, input logic [4:0] bt, input logic [4:0] ct);
    dispatch_valid  = 1'b1;
    op1_in = a;       op2_in = b;       target_in = c;
    op1_valid_in = av; op2_valid_in = bv; target_valid_in = cv;
    op1_tag_in = at;  op2_tag_in = bt;  target_tag_in = ct;
  endtask

  task automatic cdb(input logic [4:0] id, input logic [31:0] val);
    cdb_valid  = 1'b1;
    cdb_rs_id  = id;
    cdb_result = val;
  endtask

  task automatic free_ids(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      cdb(5'(i), 32'h0);
      step();
    end
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dispatch_valid = 1'b0;
    op1_in = '0; op2_in = '0; target_in = '0;
    op1_valid_in = 1'b0; op2_valid_in = 1'b0; target_valid_in = 1'b0;
    op1_tag_in = '0; op2_tag_in = '0; target_tag_in = '0;
    ctrl_a = '{mb: 5'd16, me: 5'd28, mask_insert: 1'b1, shift_right: 1'b0};
    control_in = ctrl_a;
    result_reg_addr_in = 5'd9;
    cdb_valid = 1'b0; cdb_rs_id = '0; cdb_result = '0;
    output_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_ov", 64'(output_valid), 64'd0);
    check("rst_dr", 64'(dispatch_ready), 64'd0);
    check("rst_op1", 64'(op1), 64'd0);
    rst = 1'b0;

    // Basic all-valid dispatch, issue, then free by own id
    output_ready = 1'b1;
    drive_disp(32'h05E44C80, 32'd17, 32'hFFFF0000, 1, 1, 1, 0, 0, 0);
    #1;
    check("t1_dr", 64'(dispatch_ready), 64'd1);
    check("t1_did", 64'(dispatch_rs_id), 64'd0);
    check("t1_ov0", 64'(output_valid), 64'd0);
    step();
    dispatch_valid = 1'b0;
    #1;
    check("t1_ov", 64'(output_valid), 64'd1);
    check("t1_id", 64'(rs_id_out), 64'd0);
    check("t1_op1", 64'(op1), 64'h05E44C80);
    check("t1_op2", 64'(op2), 64'd17);
    check("t1_tgt", 64'(target), 64'hFFFF0000);
    check("t1_ctrl", 64'(control), 64'(ctrl_a));
    check("t1_rd", 64'(result_reg_addr_out), 64'd9);
    step();
    #1;
    check("t1_ov_after", 64'(output_valid), 64'd0);
    check("t1_issued_held", 64'(dispatch_rs_id), 64'd1);
    cdb(5'd0, 32'h0);
    #1;
    check("t1_not_yet_free", 64'(dispatch_rs_id), 64'd1);
    step();
    cdb_valid = 1'b0;
    #1;
    check("t1_freed", 64'(dispatch_rs_id), 64'd0);

    // op2 waits on tag 7, captured from a later broadcast
    drive_disp(32'd3, 32'd99, 32'd4, 1, 0, 1, 0, 7, 0);
    step();
    dispatch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_wait", 64'(output_valid), 64'd0);
      step();
    end
    cdb(5'd7, 32'd8);
    #1;
    check("t2_bcast_cycle", 64'(output_valid), 64'd0);
    step();
    cdb_valid = 1'b0;
    #1;
    check("t2_ov", 64'(output_valid), 64'd1);
    check("t2_op2", 64'(op2), 64'd8);
    check("t2_op1", 64'(op1), 64'd3);
    step();
    free_ids(0, 0);

    // Same-cycle dispatch and matching broadcast
    drive_disp(32'd1, 32'd0, 32'd2, 1, 0, 1, 0, 7, 0);
    cdb(5'd7, 32'd17);
    step();
    dispatch_valid = 1'b0;
    cdb_valid = 1'b0;
    #1;
    check("t3_ov", 64'(output_valid), 64'd1);
    check("t3_op2", 64'(op2), 64'd17);
    step();
    free_ids(0, 0);

    // Fill all entries with output_ready low
    output_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_disp(32'(100 + i), 32'd1, 32'd2, 1, 1, 1, 0, 0, 0);
      #1;
      check("t4_did", 64'(dispatch_rs_id), 64'(i));
      step();
    end
    drive_disp(32'd999, 32'd1, 32'd2, 1, 1, 1, 0, 0, 0);
    #1;
    check("t4_full_dr", 64'(dispatch_ready), 64'd0);
    check("t4_ov", 64'(output_valid), 64'd1);
    check("t4_id0", 64'(rs_id_out), 64'd0);
    cdb(5'd2, 32'h0);
    step();
    cdb_valid = 1'b0;
    dispatch_valid = 1'b0;
    #1;
    check("t4_no_free", 64'(dispatch_ready), 64'd0);
    check("t4_hold", 64'(rs_id_out), 64'd0);
    output_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_seq_ov", 64'(output_valid), 64'd1);
      check("t4_seq_id", 64'(rs_id_out), 64'(i));
      check("t4_seq_op1", 64'(op1), 64'(100 + i));
      step();
    end
    #1;
    check("t4_drained", 64'(output_valid), 64'd0);
    free_ids(0, 3);
    #1;
    check("t4_all_free", 64'(dispatch_ready), 64'd1);
    check("t4_did0", 64'(dispatch_rs_id), 64'd0);

    // Lock: lower entry becoming ready must not displace the held selection
    output_ready = 1'b0;
    drive_disp(32'd0, 32'd5, 32'd6, 0, 1, 1, 9, 0, 0);
    step();
    drive_disp(32'h11, 32'd5, 32'd6, 1, 1, 1, 0, 0, 0);
    step();
    dispatch_valid = 1'b0;
    #1;
    check("t5_ov", 64'(output_valid), 64'd1);
    check("t5_id1", 64'(rs_id_out), 64'd1);
    cdb(5'd9, 32'h55);
    step();
    cdb_valid = 1'b0;
    #1;
    check("t5_lock_id", 64'(rs_id_out), 64'd1);
    check("t5_lock_op1", 64'(op1), 64'h11);
    output_ready = 1'b1;
    step();
    #1;
    check("t5_next_id", 64'(rs_id_out), 64'd0);
    check("t5_next_op1", 64'(op1), 64'h55);
    step();
    #1;
    check("t5_done", 64'(output_valid), 64'd0);
    free_ids(0, 1);

    // Asynchronous reset in the middle of activity
    output_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_disp(32'(i + 1), 32'd1, 32'd2, 1, 1, 1, 0, 0, 0);
      step();
    end
    dispatch_valid = 1'b0;
    #1;
    check("t6_ov_before", 64'(output_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_ov_rst", 64'(output_valid), 64'd0);
    check("t6_dr_rst", 64'(dispatch_ready), 64'd0);
    check("t6_op1_rst", 64'(op1), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("t6_dr", 64'(dispatch_ready), 64'd1);
    check("t6_did", 64'(dispatch_rs_id), 64'd0);
    check("t6_ov", 64'(output_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
